// File: rtl/moore_fsm_pkg.sv
// Shared types for the 1101 serial sequence detector.
// The pattern is fixed by the state graph; the encoding lives here so users can decode it.
package moore_fsm_pkg;

  // Each state names the longest pattern prefix seen so far.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle / no prefix
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "11"
    S3 = 3'd3,  // "110"
    S4 = 3'd4   // "1101" detected
  } state_t;

  localparam state_t DETECT_STATE = S4;

endpackage

// File: rtl/moore_fsm.sv
// Moore detector for overlapping occurrences of 1101 on a serial bit stream.
// y is decoded from the state register only, so x has no combinational path to y.
module moore_fsm
  import moore_fsm_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic x,
  output logic y
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = x ? S1 : S0;
      S1:      state_d = x ? S2 : S0;
      S2:      state_d = x ? S2 : S3;
      S3:      state_d = x ? S4 : S0;
      // Trailing '1' of the match plus a new '1' already forms "11".
      S4:      state_d = x ? S2 : S0;
      default: state_d = S0;
    endcase
  end

  assign y = (state_q == DETECT_STATE);

endmodule

// File: tb/tb_moore_fsm.sv
// Self-checking bench for moore_fsm: directed vector tables, reset corner cases,
// and random stimulus against a sliding-window model of the 1101 pattern.
module tb_moore_fsm;

  logic clk;
  logic nrst;
  logic x;
  logic y;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: last four sampled bits since reset; zero-filled so a match needs four real bits.
  logic [3:0] hist;

  typedef struct {
    logic xv;
    logic ey;
  } vec_t;

  vec_t vecs[$];

  moore_fsm dut (
    .clk  (clk),
    .nrst (nrst),
    .x    (x),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_y();
    return (hist == 4'b1101);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: y=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive x, let one rising edge sample it, return to the falling edge.
  task automatic apply(input logic xv);
    x = xv;
    @(posedge clk);
    hist = {hist[2:0], xv};
    @(negedge clk);
  endtask

  task automatic apply_chk(input string name, input logic xv);
    apply(xv);
    chk(name, y, model_y());
  endtask

  task automatic do_reset(input string name, input int cycles);
    nrst = 1'b0;
    hist = 4'b0000;
    for (int i = 0; i < cycles; i++) begin
      x = ~x;
      @(negedge clk);
      chk(name, y, 1'b0);
    end
    nrst = 1'b1;
  endtask

  initial begin
    nrst = 1'b0;
    x    = 1'b0;
    hist = 4'b0000;

    // Reset held across edges with x toggling.
    @(negedge clk);
    do_reset("reset_hold", 2);
    #1 chk("reset_release", y, 1'b0);
    @(negedge clk);
    chk("reset_idle", y, 1'b0);

    // Directed tables: basic detect, overlap, S2 self-loop, non-match.
    begin
      logic [0:4]  t2x = 5'b11010, t2y = 5'b00010;
      logic [0:7]  t3x = 8'b11011010, t3y = 8'b00010010;
      logic [0:6]  t4x = 7'b1111010, t4y = 7'b0000010;
      logic [0:3]  t5x = 4'b1010, t5y = 4'b0000;
      for (int i = 0; i < 5; i++) vecs.push_back('{xv: t2x[i], ey: t2y[i]});
      for (int i = 0; i < 8; i++) vecs.push_back('{xv: t3x[i], ey: t3y[i]});
      for (int i = 0; i < 7; i++) vecs.push_back('{xv: t4x[i], ey: t4y[i]});
      for (int i = 0; i < 4; i++) vecs.push_back('{xv: t5x[i], ey: t5y[i]});
    end
    foreach (vecs[i]) begin
      apply(vecs[i].xv);
      chk($sformatf("table[%0d]", i), y, vecs[i].ey);
    end

    // Reset mid-sequence discards the "110" prefix.
    apply_chk("mid_pre", 1'b1);
    apply_chk("mid_pre", 1'b1);
    apply_chk("mid_pre", 1'b0);
    do_reset("mid_reset", 2);
    apply(1'b1);
    chk("mid_after_1", y, 1'b0);
    apply(1'b1); chk("mid_seq", y, 1'b0);
    apply(1'b1); chk("mid_seq", y, 1'b0);
    apply(1'b0); chk("mid_seq", y, 1'b0);
    apply(1'b1); chk("mid_detect", y, 1'b1);

    // Async reset while in the detect state drops y before the next rising edge.
    apply(1'b0);
    apply(1'b1); apply(1'b1); apply(1'b0);
    apply(1'b1); chk("async_pre", y, 1'b1);
    #2 nrst = 1'b0;
    hist = 4'b0000;
    #1 chk("async_drop", y, 1'b0);
    @(negedge clk);
    chk("async_hold", y, 1'b0);
    nrst = 1'b1;
    x = 1'b0;

    // Random stream with occasional resets, checked against the window model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rand_reset", 1);
      end else begin
        // Bias toward 1s so matches happen often.
        apply_chk("random", ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
